// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned AW_DEFAULT       = 16;
  localparam int unsigned DW_DEFAULT       = 8;
  localparam int unsigned MAX_WAIT_DEFAULT = 64;
  localparam int unsigned WAIT_CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } cpu_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    VID    = 2'd1,
    CPU    = 2'd2,
    STOLEN = 2'd3
  } slot_tag_t;

endpackage

// File: rtl/vram_arb_tagpipe.sv
// Two-stage slot-owner tag delay; decodes video valid/dropped.
// Dropped decode exists only when ARB_STARVE_GUARD_EN is defined.
module vram_arb_tagpipe
  import vram_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  slot_tag_t tag_i,
  output logic      vid_valid_o,
  output logic      vid_dropped_o
);

  slot_tag_t tag1_q, tag2_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag1_q <= NONE;
      tag2_q <= NONE;
    end else begin
      tag1_q <= tag_i;
      tag2_q <= tag1_q;
    end
  end

  assign vid_valid_o = (tag2_q == VID);

`ifdef ARB_STARVE_GUARD_EN
  assign vid_dropped_o = (tag2_q == STOLEN);
`else
  assign vid_dropped_o = 1'b0;
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-priority video fetch, CPU req/ack in free slots.
// Optional CPU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEFAULT,
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic [DW-1:0] vid_data_o,
  output logic          vid_valid_o,
  output logic          vid_dropped_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  cpu_state_t    state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          cpu_grant;
  logic          force_grant;
  slot_tag_t     slot_tag;

`ifdef ARB_STARVE_GUARD_EN
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign force_grant = (state_q == IDLE) && cpu_req_i && vid_req_i &&
                       (wait_cnt_q == WAIT_CNT_W'(MAX_WAIT - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!cpu_req_i || cpu_grant) begin
      wait_cnt_d = '0;
    end else if ((state_q == IDLE) && vid_req_i) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign force_grant     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    cpu_grant   = 1'b0;
    slot_tag    = NONE;

    case (state_q)
      IDLE: begin
        if (cpu_req_i && (!vid_req_i || force_grant)) begin
          cpu_grant = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d     = ACK;
        cpu_rdata_d = mem_rdata_i;
        cpu_ack_d   = 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Only the IDLE->ISSUE slot competes with video, so mem_we can never repeat.
    if (cpu_grant) begin
      mem_addr_d  = cpu_addr_i;
      mem_we_d    = cpu_we_i;
      mem_wdata_d = cpu_wdata_i;
      slot_tag    = force_grant ? STOLEN : CPU;
    end else if (vid_req_i) begin
      mem_addr_d = vid_addr_i;
      slot_tag   = VID;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  vram_arb_tagpipe u_tagpipe (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .tag_i        (slot_tag),
    .vid_valid_o  (vid_valid_o),
    .vid_dropped_o(vid_dropped_o)
  );

  assign vid_data_o  = mem_rdata_i;
  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural 1-cycle BRAM.
// Builds with or without ARB_STARVE_GUARD_EN; DUT uses MAX_WAIT=8.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid, vid_dropped;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_data_o(vid_data),
    .vid_valid_o(vid_valid), .vid_dropped_o(vid_dropped),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Video scoreboard: expected slot results pushed at drive time with due cycle.
  typedef struct {
    int         due;
    logic       dropped;
    logic [7:0] data;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  int  ack_count = 0, ack_cyc = 0, drop_count = 0, we_count = 0;
  logic [7:0] ack_rdata = '0;
  logic prev_we = 1'b0, prev_ack = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (vid_valid || vid_dropped) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: valid=%0b dropped=%0b with nothing expected (cycle %0d)",
                   vid_valid, vid_dropped, cyc);
        end else begin
          sb_e = sb.pop_front();
          if (sb_e.due != cyc || vid_dropped != sb_e.dropped || vid_valid == sb_e.dropped ||
              (!sb_e.dropped && vid_data != sb_e.data)) begin
            errors++;
            $display("FAIL sb_video: cycle %0d valid=%0b dropped=%0b data=0x%0h, expected cycle %0d dropped=%0b data=0x%0h",
                     cyc, vid_valid, vid_dropped, vid_data, sb_e.due, sb_e.dropped, sb_e.data);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        sb_e = sb.pop_front();
        $display("FAIL sb_missing: no video result at cycle %0d, expected data 0x%0h due %0d",
                 cyc, sb_e.data, sb_e.due);
      end
      if (vid_dropped) drop_count++;
      if (cpu_ack) begin
        ack_count++;
        ack_cyc   = cyc;
        ack_rdata = cpu_rdata;
        checks++;
        if (prev_ack) begin
          errors++;
          $display("FAIL ack_width: cpu_ack high two cycles, got 1 expected 0 (cycle %0d)", cyc);
        end
      end
      if (mem_we) begin
        we_count++;
        checks++;
        if (prev_we) begin
          errors++;
          $display("FAIL we_consecutive: mem_we high two cycles, got 1 expected 0 (cycle %0d)", cyc);
        end
      end
    end
    prev_we  = reset ? 1'b0 : mem_we;
    prev_ack = reset ? 1'b0 : cpu_ack;
  end

  task automatic push_vid(input logic [15:0] addr, input logic dropped);
    sb_e.due     = cyc + 2;
    sb_e.dropped = dropped;
    sb_e.data    = addr[7:0];
    sb.push_back(sb_e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_addr"},  int'(mem_addr), 0);
    chk({tag, "_mem_we"},    int'(mem_we), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_cpu_rdata"}, int'(cpu_rdata), 0);
    chk({tag, "_cpu_ack"},   int'(cpu_ack), 0);
    chk({tag, "_vid_valid"}, int'(vid_valid), 0);
    chk({tag, "_vid_drop"},  int'(vid_dropped), 0);
  endtask

  task automatic wait_ack(input int a0, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (ack_count != a0) got = 1'b1;
    end
    chk("ack_arrived", int'(got), 1);
  endtask

  typedef struct {
    logic       we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } cpu_vec_t;
  cpu_vec_t vecs [6];

  task automatic cpu_access(input cpu_vec_t v);
    int a0, w0, c0;
    bit got;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    c0 = cyc; a0 = ack_count; w0 = we_count;
    wait_ack(a0, 10, got);
    chk("cpu_latency", ack_cyc - c0, 3);
    chk("cpu_we_pulses", we_count - w0, v.we ? 1 : 0);
    if (!v.we) chk("cpu_rdata", int'(ack_rdata), int'(v.exp_rdata));
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("ack_dropped", int'(cpu_ack), 0);
  endtask

  int  c0, a0, d0;
  bit  got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i);

    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 16'h1234, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 16'h00FF, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 16'h00FF, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 16'h2077, 8'h00, 8'h77};
    vecs[5] = '{1'b0, 16'h1234, 8'h00, 8'hA5};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Video only: 16 back-to-back fetches, no gaps.
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      vid_req = 1'b1; vid_addr = 16'h1000 + 16'(k);
      push_vid(vid_addr, 1'b0);
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("video_drain", sb.size(), 0);

    // CPU transactions with idle video.
    for (int i = 0; i < 6; i++) cpu_access(vecs[i]);

    // Contention: video for 10 cycles, CPU read waits for the first free slot.
    a0 = ack_count;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      vid_req = 1'b1; vid_addr = 16'h2000 + 16'(k);
      push_vid(vid_addr, 1'b0);
      if (k == 3) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      end
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
    c0 = cyc;
    chk("contend_no_early_ack", ack_count - a0, 0);
    wait_ack(a0, 10, got);
    chk("contend_latency", ack_cyc - c0, 3);
    chk("contend_rdata", int'(ack_rdata), 8'hA5);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("contend_drain", sb.size(), 0);

`ifdef ARB_STARVE_GUARD_EN
    // Starvation guard: forced grant on the 8th contended edge.
    a0 = ack_count; d0 = drop_count; c0 = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        c0 = cyc;
      end
      if (ack_count != a0) cpu_req = 1'b0;
      vid_req = 1'b1; vid_addr = 16'h3000 + 16'(k);
      push_vid(vid_addr, k == 7);
    end
    @(posedge clk); #1;
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("guard_ack_count", ack_count - a0, 1);
    chk("guard_latency", ack_cyc - c0, 10);
    chk("guard_rdata", int'(ack_rdata), 8'hA5);
    chk("guard_drop_count", drop_count - d0, 1);
    chk("guard_drain", sb.size(), 0);
`else
    // No guard: CPU starves for 100 cycles, video never dropped.
    a0 = ack_count; d0 = drop_count;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      end
      vid_req = 1'b1; vid_addr = 16'h4000 + 16'(k);
      push_vid(vid_addr, 1'b0);
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
    c0 = cyc;
    chk("starve_no_ack", ack_count - a0, 0);
    chk("starve_no_drop", drop_count - d0, 0);
    wait_ack(a0, 10, got);
    chk("starve_release_latency", ack_cyc - c0, 3);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("starve_drain", sb.size(), 0);
`endif

    // Reset while the FSM sits in WAIT: no ack, outputs cleared at once.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    a0 = ack_count;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    cpu_req = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_ack", ack_count - a0, 0);
    reset = 1'b0;
    cpu_access(vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
